// File: rtl/yabot_pkg.sv
// Shared types and constants for the dwell driver slice.
package yabot_pkg;

    typedef enum logic [1:0] {
        LOW_IDLE  = 2'd0,
        HIGH_HOLD = 2'd1,
        HIGH_IDLE = 2'd2,
        LOW_HOLD  = 2'd3
    } dwell_state_t;

    localparam string MODE_LEVEL = "LEVEL";
    localparam string MODE_PULSE = "PULSE";

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Load has priority; otherwise count down and stick at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dwell_driver.sv
// Output dwell shaper: enforces minimum high/low times on out_data.
// Optional build macro DWELL_PENDING_EN adds a saturating queue of
// PULSE requests that arrive while a pulse is in progress.
module dwell_driver
    import yabot_pkg::*;
#(
    parameter int    HIGH_TIME = 1000,
    parameter int    LOW_TIME  = 1000,
    parameter string MODE      = "LEVEL",
    parameter int    PEND_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_data,
    output logic out_data,
    output logic busy,
    output logic drop
);

    localparam bit IS_PULSE = (MODE == MODE_PULSE);
    localparam int CW       = $clog2(max_int(HIGH_TIME, LOW_TIME) + 1);

    if (HIGH_TIME < 1 || LOW_TIME < 1 || PEND_W < 1 ||
        !(MODE == MODE_LEVEL || MODE == MODE_PULSE)) begin : g_param_err
        $error("dwell_driver: illegal parameter set");
    end

    dwell_state_t  state, state_nx;
    logic [CW-1:0] cnt, load_val;
    logic          load, zero;
    logic          restart;   // end of a low dwell: a new high may start now
    logic          pend_nz;

    dwell_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .zero     (zero)
    );

`ifdef DWELL_PENDING_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    logic [PEND_W-1:0] pend, pend_nx;

    // Pending-pulse counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_nx;
    end

    assign pend_nz = (pend != '0);
`else
    assign pend_nz = 1'b0;
`endif

    assign restart = (state == LOW_HOLD) && zero;

    // Next state, timer load and request bookkeeping
    always_comb begin
        state_nx = state;
        drop     = 1'b0;
`ifdef DWELL_PENDING_EN
        pend_nx  = pend;
`endif
        case (state)
            LOW_IDLE:  if (in_data) state_nx = HIGH_HOLD;
            HIGH_HOLD: if (zero) state_nx = (!IS_PULSE && in_data) ? HIGH_IDLE : LOW_HOLD;
            HIGH_IDLE: if (!in_data) state_nx = LOW_HOLD;
            LOW_HOLD:  if (zero) state_nx = (in_data || (IS_PULSE && pend_nz)) ? HIGH_HOLD : LOW_IDLE;
            default:   state_nx = LOW_IDLE;
        endcase

        if (IS_PULSE) begin
            // A strobe at the end of a low dwell is served directly (it takes
            // the slot a queued pulse would use, so the queue is unchanged).
            if (in_data && state != LOW_IDLE && !restart) begin
`ifdef DWELL_PENDING_EN
                if (pend == PEND_MAX) drop = 1'b1;
                else                  pend_nx = pend + 1'b1;
`else
                drop = 1'b1;
`endif
            end
`ifdef DWELL_PENDING_EN
            else if (!in_data && restart && pend_nz) begin
                pend_nx = pend - 1'b1;
            end
`endif
        end

        load     = (state_nx != state) && (state_nx == HIGH_HOLD || state_nx == LOW_HOLD);
        load_val = (state_nx == HIGH_HOLD) ? CW'(HIGH_TIME - 1) : CW'(LOW_TIME - 1);
    end

    // State register; out_data is registered from the next state so it never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOW_IDLE;
            out_data <= 1'b0;
        end else begin
            state    <= state_nx;
            out_data <= (state_nx == HIGH_HOLD) || (state_nx == HIGH_IDLE);
        end
    end

    assign busy = (state != LOW_IDLE);

endmodule
